par2ser_tx: RTL and testbench
=============================

PAR2SER_TX -- requirements
Module: par2ser_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning serial bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, WIDTH bits: parallel word to transmit.
REQ-006 SHALL have port in_val, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_rdy, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port rx_data, output, 1 bit: serial data bit, the stream a serial-to-parallel receiver consumes.
REQ-009 SHALL have port rx_val, output, 1 bit: rx_data is valid this cycle.
REQ-010 SHALL have port index, output, 32 bits: ordinal of the word currently on rx_data.

Function
REQ-011 SHALL accept a word on a rising edge where in_val=1 and in_rdy=1; no other condition accepts a word.
REQ-012 SHALL contain a shift register, a bit counter (0..WIDTH-1), a one-entry holding register with flag hold_full, and a 32-bit word counter word_cnt.
REQ-013 SHALL implement a two-state FSM: IDLE (shifter empty) and SHIFT (shifter driving a word).
REQ-014 SHALL drive in_rdy combinationally as !hold_full, independent of in_val.
REQ-015 IDLE: an accepted word SHALL load directly into the shifter; FSM -> SHIFT; rx_val=1 with that word's first bit on the cycle after acceptance (latency 1).
REQ-016 SHIFT, bit counter < WIDTH-1: an accepted word SHALL go to the holding register (hold_full<=1); the shifter advances one bit per cycle.
REQ-017 SHIFT, last bit (counter = WIDTH-1), hold_full=1: the shifter SHALL load from the holding register and clear hold_full on the same edge; no idle cycle.
REQ-018 SHIFT, last bit, hold_full=0, word accepted that edge: the shifter SHALL load it directly; no idle cycle.
REQ-019 SHIFT, last bit, hold_full=0, nothing accepted: FSM SHALL return to IDLE; rx_val=0 on the next cycle.
REQ-020 rx_val SHALL be 1 exactly in SHIFT; rx_data SHALL be 0 whenever rx_val=0.
REQ-021 Every shifter load SHALL set index<=word_cnt and word_cnt<=word_cnt+1, wrapping modulo 2^32; index SHALL hold steady across all WIDTH bits of a word.
REQ-022 Sustained in_val=1 SHALL yield a gap-free stream of rx_val=1, one bit per cycle, exactly WIDTH bits per word.
REQ-023 Words SHALL be emitted in acceptance order; none dropped or duplicated.
REQ-024 in_data SHALL be captured at acceptance; later changes to in_data SHALL not affect the word already captured.
REQ-025 With hold_full=1 and in_val=1, in_rdy=0 SHALL stall the source; the word is not captured until in_rdy=1.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force: FSM=IDLE, hold_full=0, bit counter=0, word_cnt=0, index=0, rx_val=0, rx_data=0, in_rdy=1.
REQ-027 rst asserted mid-word SHALL discard the partial word and any held word; after release, the first accepted word SHALL get index=0.
REQ-028 While rst=1, no word SHALL be accepted.

Verification
REQ-029 Single word: WIDTH=32, MSB_FIRST=1, in_data=32'hA5000001 accepted at cycle 0 -> rx_val=1 cycles 1..32; bits 1,0,1,0,0,1,0,1,0... ending 1; index=0; rx_val=0 at cycle 33.
REQ-030 Back-to-back: 3 words 32'h1, 32'h2, 32'h3 with in_val held 1 -> 96 consecutive rx_val=1 cycles; index 0,1,2; in_rdy=0 while hold full.
REQ-031 LSB-first: MSB_FIRST=0, in_data=32'h00000003 -> first two bits 1,1, remaining 30 bits 0.
REQ-032 Stall: hold full and in_val=1 with 32'hDEADBEEF -> in_rdy=0 until the first word's last bit; DEADBEEF follows with no gap and is emitted intact.
REQ-033 Reset mid-word: rst pulsed at bit 10 of word 5 -> rx_val=0 asynchronously; next accepted word emits with index=0.
REQ-034 Wrap: word_cnt forced/preloaded to 32'hFFFFFFFF -> that word has index=FFFFFFFF, the next word has index=0.

Source files
------------

// File: rtl/par2ser_tx_if.sv
// rtl/par2ser_tx_if.sv - parallel word input and serial bit output bundle for par2ser_tx
interface par2ser_tx_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_data;
  logic             in_val;
  logic             in_rdy;
  logic             rx_data;
  logic             rx_val;
  logic [31:0]      index;

  modport master (
    output in_data, in_val,
    input  in_rdy, rx_data, rx_val, index
  );

  modport slave (
    input  in_data, in_val,
    output in_rdy, rx_data, rx_val, index
  );
endinterface

// File: rtl/par2ser_tx.sv
// rtl/par2ser_tx.sv - parallel-to-serial transmitter with one-word holding register and word numbering
module par2ser_tx #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  par2ser_tx_if.slave  bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;
  logic [31:0]      word_cnt;
  logic [31:0]      index_q;

  logic accept, last_bit, load_hold, load_direct, load, to_hold;

  assign bus.in_rdy  = !hold_full;
  assign accept      = bus.in_val && !hold_full;
  assign last_bit    = (state == SHIFT) && (bit_cnt == LAST);
  // The held word always wins the shifter slot; a new word can only go direct when nothing is held.
  assign load_hold   = last_bit && hold_full;
  assign load_direct = accept && ((state == IDLE) || (last_bit && !hold_full));
  assign load        = load_hold || load_direct;
  assign to_hold     = accept && (state == SHIFT) && !last_bit;
  assign bus.index   = index_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.rx_val  = 1'b0;
    bus.rx_data = 1'b0;
    if (state == SHIFT) begin
      bus.rx_val  = 1'b1;
      bus.rx_data = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      index_q   <= '0;
    end else begin
      if (load) begin
        shreg    <= load_hold ? hold_reg : bus.in_data;
        bit_cnt  <= '0;
        index_q  <= word_cnt;
        word_cnt <= word_cnt + 32'd1;
      end else if (state == SHIFT) begin
        shreg   <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + CW'(1);
      end

      if (to_hold) begin
        hold_reg  <= bus.in_data;
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_par2ser_tx.sv
// tb/tb_par2ser_tx.sv - randomized and directed bench for par2ser_tx against a word-queue reference model
module tb_par2ser_tx;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  par2ser_tx_if #(.WIDTH(W)) bm ();
  par2ser_tx_if #(.WIDTH(W)) bl ();

  par2ser_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut     (.clk(clk), .rst(rst), .bus(bm.slave));
  par2ser_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(bl.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int val_cnt = 0;

  // Reference model: the word being sent, bits still to send, and at most one waiting word.
  logic [31:0] m_cur = '0;
  int          m_left = 0;
  logic [31:0] m_held[$];
  logic [31:0] m_cnt = '0;
  logic [31:0] m_idx = '0;
  bit          m_acc = 1'b0;

  logic        t_val = 1'b0;
  logic [31:0] t_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    t_val = v;
    t_data = d;
    bm.in_val = v;  bm.in_data = d;
    bl.in_val = v;  bl.in_data = d;
  endtask

  function automatic void model_reset();
    m_left = 0;
    m_held.delete();
    m_cnt = '0;
    m_idx = '0;
    m_acc = 1'b0;
  endfunction

  function automatic void model_edge();
    bit take;
    if (rst) begin
      model_reset();
      return;
    end
    m_acc = t_val && (m_held.size() == 0);
    take = m_acc;
    if (m_left > 0) m_left--;
    if (m_left == 0) begin
      if (m_held.size() > 0) begin
        m_cur = m_held.pop_front();
        m_left = W; m_idx = m_cnt; m_cnt = m_cnt + 32'd1;
      end else if (take) begin
        m_cur = t_data;
        m_left = W; m_idx = m_cnt; m_cnt = m_cnt + 32'd1;
        take = 1'b0;
      end
    end
    if (take) m_held.push_back(t_data);
  endfunction

  task automatic check_outputs();
    logic ev, em, el;
    int pos;
    ev = (m_left > 0);
    em = 1'b0; el = 1'b0;
    if (ev) begin
      pos = W - m_left;
      em = m_cur[W-1-pos];
      el = m_cur[pos];
    end
    chk("rdy_msb", {31'd0, bm.in_rdy}, {31'd0, m_held.size() == 0});
    chk("rdy_lsb", {31'd0, bl.in_rdy}, {31'd0, m_held.size() == 0});
    chk("val_msb", {31'd0, bm.rx_val}, {31'd0, ev});
    chk("val_lsb", {31'd0, bl.rx_val}, {31'd0, ev});
    chk("bit_msb", {31'd0, bm.rx_data}, {31'd0, em});
    chk("bit_lsb", {31'd0, bl.rx_data}, {31'd0, el});
    if (ev) begin
      chk("idx_msb", bm.index, m_idx);
      chk("idx_lsb", bl.index, m_idx);
    end
    if (bm.rx_val === 1'b1) val_cnt++;
  endtask

  task automatic cycle(input logic v, input logic [31:0] d);
    drive(v, d);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic send_list(input logic [31:0] words[$]);
    int i = 0;
    int budget = 0;
    while (i < words.size() && budget < 1000) begin
      cycle(1'b1, words[i]);
      if (m_acc) i++;
      budget++;
    end
    if (i < words.size()) chk("send_timeout", budget, 0);
    drive(1'b0, $urandom);
  endtask

  task automatic drain();
    int budget = 0;
    while ((m_left > 0 || m_held.size() > 0) && budget < 200) begin
      cycle(1'b0, $urandom);
      budget++;
    end
    if (m_left > 0 || m_held.size() > 0) chk("drain_timeout", budget, 0);
  endtask

  initial begin
    logic [31:0] wl[$];
    int budget;

    drive(1'b1, 32'h12345678);
    @(negedge clk);
    model_reset();
    repeat (3) cycle(1'b1, 32'h12345678);
    chk("rst_index", bm.index, 32'd0);
    rst = 1'b0;

    // Single word with one-cycle latency.
    val_cnt = 0;
    cycle(1'b1, 32'hA5000001);
    drive(1'b0, 32'hFFFFFFFF);
    chk("latency1", {31'd0, bm.rx_val}, 32'd1);
    chk("first_bit", {31'd0, bm.rx_data}, 32'd1);
    repeat (40) cycle(1'b0, $urandom);
    chk("a5_len", val_cnt, 32);

    // Back-to-back with stall on the fourth word.
    val_cnt = 0;
    wl = '{32'h1, 32'h2, 32'h3, 32'hDEADBEEF};
    send_list(wl);
    drain();
    chk("b2b_len", val_cnt, 128);

    wl = '{32'h00000003};
    send_list(wl);
    drain();

    for (int i = 0; i < 1500; i++) cycle($urandom_range(0, 3) != 0, $urandom);
    drain();

    // Reset in the middle of word 5, bit 10.
    rst = 1'b1;
    cycle(1'b0, 32'h0);
    rst = 1'b0;
    budget = 0;
    while (!(m_left > 0 && m_idx == 32'd5 && (W - m_left) == 10) && budget < 400) begin
      cycle(1'b1, $urandom);
      budget++;
    end
    chk("reach_word5", {31'd0, budget < 400}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_val", {31'd0, bm.rx_val}, 32'd0);
    chk("arst_data", {31'd0, bm.rx_data}, 32'd0);
    chk("arst_index", bm.index, 32'd0);
    chk("arst_rdy", {31'd0, bm.in_rdy}, 32'd1);
    model_reset();
    @(negedge clk);
    cycle(1'b1, $urandom);
    rst = 1'b0;
    wl = '{32'hC0FFEE00};
    send_list(wl);
    chk("idx_after_rst", bm.index, 32'd0);
    drain();

    // Word counter wrap.
    drive(1'b0, 32'h0);
    force dut.word_cnt = 32'hFFFFFFFF;
    force dut_lsb.word_cnt = 32'hFFFFFFFF;
    cycle(1'b0, 32'h0);
    release dut.word_cnt;
    release dut_lsb.word_cnt;
    m_cnt = 32'hFFFFFFFF;
    wl = '{32'hAAAA5555};
    send_list(wl);
    chk("wrap_idx_ff", bm.index, 32'hFFFFFFFF);
    wl = '{32'h0F0F0F0F};
    send_list(wl);
    drain();
    chk("wrap_idx_0", bm.index, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
